// File: rtl/ni_in_buffer_pkg.sv
// ni_in_buffer_pkg -- NoC parameters shared by the receive and transmit sides.
//   Flit-type constants (carried in the top two bits of every flit) and
//   the packet-framing state encoding used by pkt_frame_checker.
package ni_in_buffer_pkg;

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEADER = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pkt_state_e;

endpackage

// File: rtl/ni_in_buffer_pkt_frame_checker.sv
// pkt_frame_checker -- framing FSM watching accepted flits.
//   clk, rst      : clock, synchronous active-high reset
//   accept        : a flit is being written into the buffer this cycle
//   flit_type     : type bits of that flit
//   pkt_error     : sticky, set on the first malformed flit until reset
//   err_count     : number of malformed flits, saturating at 255
// Observes only; never stalls or drops data.
module pkt_frame_checker
  import ni_in_buffer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       accept,
  input  logic [1:0] flit_type,
  output logic       pkt_error,
  output logic [7:0] err_count
);

  pkt_state_e state, state_next;
  logic       frame_err;

  always_comb begin
    state_next = state;
    frame_err  = 1'b0;
    if (accept) begin
      unique case (state)
        IDLE: begin
          if (flit_type == FT_HEADER) state_next = IN_PKT;
          else if (flit_type != FT_SINGLE) frame_err = 1'b1;
        end
        IN_PKT: begin
          if (flit_type == FT_TAIL) begin
            state_next = IDLE;
          end else if (flit_type == FT_HEADER) begin
            frame_err = 1'b1;
          end else if (flit_type == FT_SINGLE) begin
            frame_err  = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pkt_error <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_next;
      if (frame_err) begin
        pkt_error <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: rtl/ni_in_buffer.sv
// ni_in_buffer -- receive-side flit FIFO on a STALL_GO link.
//   clk, rst     : clock, synchronous active-high reset
//   FLIT_in      : incoming flit, VALID_in qualifies it
//   FWDAUX1_in   : unused on STALL_GO
//   BWDAUX1_out  : STALL to upstream (buffer full), registered state only
//   BWDAUX2_out, BWDAUX3_out : tied 0
//   read         : consumer pops the head flit (ignored while empty)
//   data_out     : head flit, empty : no flit stored
//   pkt_error, err_count : framing check results
// Optional feature: define IN_BUFFER_PKT_CHECK_EN to build the framing
// checker; otherwise pkt_error and err_count are tied 0.
module ni_in_buffer
  import ni_in_buffer_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH          = 32,
  parameter int unsigned IN_BUFFER_DEPTH     = 4,
  parameter int unsigned LOG_IN_BUFFER_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] FLIT_in,
  input  logic                  VALID_in,
  input  logic                  FWDAUX1_in,
  output logic                  BWDAUX1_out,
  output logic                  BWDAUX2_out,
  output logic                  BWDAUX3_out,
  input  logic                  read,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  pkt_error,
  output logic [7:0]            err_count
);

  localparam logic [LOG_IN_BUFFER_DEPTH:0]   FULL_COUNT = IN_BUFFER_DEPTH[LOG_IN_BUFFER_DEPTH:0];
  localparam logic [LOG_IN_BUFFER_DEPTH-1:0] LAST_SLOT  = LOG_IN_BUFFER_DEPTH'(IN_BUFFER_DEPTH - 1);

  logic [FLIT_WIDTH-1:0]          buffer [IN_BUFFER_DEPTH];
  logic [LOG_IN_BUFFER_DEPTH-1:0] pointer_in, pointer_out;
  logic [LOG_IN_BUFFER_DEPTH:0]   elements;
  logic                           accept, pop;
  logic                           unused_fwdaux1;

  assign unused_fwdaux1 = FWDAUX1_in;

  // Stall comes from the element count alone: a pop on a full buffer does
  // not free the slot for the same cycle's upstream flit.
  assign BWDAUX1_out = (elements == FULL_COUNT);
  assign BWDAUX2_out = 1'b0;
  assign BWDAUX3_out = 1'b0;
  assign empty       = (elements == '0);
  assign data_out    = buffer[pointer_out];

  assign accept = VALID_in && !BWDAUX1_out;
  assign pop    = read && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < IN_BUFFER_DEPTH; i++) buffer[i] <= '0;
      pointer_in  <= '0;
      pointer_out <= '0;
      elements    <= '0;
    end else begin
      if (accept) begin
        buffer[pointer_in] <= FLIT_in;
        pointer_in <= (pointer_in == LAST_SLOT) ? '0 : pointer_in + 1'b1;
      end
      if (pop) begin
        pointer_out <= (pointer_out == LAST_SLOT) ? '0 : pointer_out + 1'b1;
      end
      case ({accept, pop})
        2'b10:   elements <= elements + 1'b1;
        2'b01:   elements <= elements - 1'b1;
        default: elements <= elements;
      endcase
    end
  end

`ifdef IN_BUFFER_PKT_CHECK_EN
  pkt_frame_checker u_pkt_frame_checker (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .flit_type (FLIT_in[FLIT_WIDTH-1:FLIT_WIDTH-2]),
    .pkt_error (pkt_error),
    .err_count (err_count)
  );
`else
  assign pkt_error = 1'b0;
  assign err_count = '0;
`endif

endmodule
